// File: rtl/imem_sync_if.sv
// imem_sync_if: fetch request/response, program-load and status signals of the instruction memory
interface imem_sync_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              busy;
  modport master (
    output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy
  );
  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/imem_sync.sv
// imem_sync: clocked instruction RAM with wait-state fetch handshake and program-load port
// Optional IMEM_RANGE_CHECK_EN: fault fetches and drop loads at or above DEPTH*4 instead of wrapping.
module imem_sync #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256,
  parameter int WAIT   = 1
) (
  input  logic      clk,
  input  logic      rst,
  imem_sync_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(WAIT == 0 ? 0 : WAIT - 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, rd_addr;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept, fire, rd_err, ld_ok, unused_bits;
  logic [IW-1:0]     rd_idx, ld_idx;
  assign bus.req_ready = !bus.ld_en && (state_q == S_IDLE || (state_q == S_RESP && bus.rsp_ready));
  assign accept        = bus.req_valid && bus.req_ready;
  // the array is read on the edge that enters RESP, straight from req_addr when there are no wait states
  assign fire          = (state_q == S_WAIT && cnt_q == 4'd0) || (accept && WAIT == 0);
  assign rd_addr       = state_q == S_WAIT ? addr_q : bus.req_addr;
  assign rd_idx        = rd_addr[IW+1:2];
  assign ld_idx        = bus.ld_addr[IW+1:2];
  assign unused_bits   = ^{rd_addr, bus.ld_addr};
`ifdef IMEM_RANGE_CHECK_EN
  assign rd_err = rd_addr[1:0] != 2'b00 || (rd_addr >> (IW + 2)) != '0;
  assign ld_ok  = (bus.ld_addr >> (IW + 2)) == '0;
`else
  assign rd_err = rd_addr[1:0] != 2'b00;
  assign ld_ok  = 1'b1;
`endif
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rsp_data_d = fire ? (rd_err ? '0 : mem[rd_idx]) : rsp_data_q;
    rsp_err_d  = fire ? rd_err : rsp_err_q;
    if (accept) begin
      addr_d  = bus.req_addr;
      cnt_d   = CNT_INIT;
      state_d = WAIT == 0 ? S_RESP : S_WAIT;
    end else if (state_q == S_WAIT) begin
      cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      state_d = cnt_q == 4'd0 ? S_RESP : S_WAIT;
    end else if (state_q == S_RESP && bus.rsp_ready) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (bus.ld_en && ld_ok) mem[ld_idx] <= bus.ld_data;
  end
  assign bus.rsp_valid = state_q == S_RESP;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = state_q != S_IDLE;
endmodule

// File: doc/imem_sync.md
Name: imem_sync

Overview:
Parametrised, clocked instruction memory; successor to the fixed combinational instruction ROM in the MIPS core.
- Word-addressed RAM array with a program-load port for boot/testbench loading.
- Request/response fetch handshake with configurable wait states, response backpressure, misalignment fault.
- Sits between the fetch stage and the loader; fetch stalls on req_ready/rsp_valid.

Parameters:
DATA_W, 32, instruction word width in bits
ADDR_W, 32, byte address width
DEPTH, 256, number of words (power of two, >=2)
WAIT, 1, extra wait-state cycles per fetch (0..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  fetch request valid
req_ready  out  1  fetch request accepted when valid&&ready
req_addr  in  ADDR_W  byte address of fetch
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_data  out  DATA_W  fetched instruction
rsp_err  out  1  fault flag for this response
ld_en  in  1  program-load write strobe
ld_addr  in  ADDR_W  byte address of load (low 2 bits ignored)
ld_data  in  DATA_W  word to write
busy  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, WAIT, RESP. Reset (rst=1 at edge) -> IDLE; rsp_valid=0, rsp_data=0, rsp_err=0, wait counter=0. Memory contents NOT cleared by reset.
- req_ready = !ld_en && (state==IDLE || (state==RESP && rsp_ready)). Combinational.
- Accept (req_valid&&req_ready at edge): latch req_addr. WAIT=0 -> RESP next cycle; else -> WAIT with counter=WAIT-1.
- WAIT: counter decrements each cycle; at counter==0 -> RESP next edge. ld_en does not stall counter.
- Latency: request accepted at edge N -> rsp_valid high from cycle after edge N+WAIT.
- Array read happens at the edge entering RESP; rsp_data/rsp_err registered then and held stable while rsp_valid && !rsp_ready.
- RESP: rsp_valid=1. rsp_ready=1 -> response retired; if new request accepted same edge -> WAIT/RESP per above (back-to-back, throughput 1 per WAIT+1 cycles); else -> IDLE, rsp_valid=0.
- Index = addr[log2(DEPTH)+1:2]; upper bits ignored (wrap) unless optional feature enabled.
- Misaligned (latched addr[1:0]!=0): rsp_err=1, rsp_data=0, same latency, no array read.
- Load: ld_en=1 writes ld_data to mem[ld_addr index] at edge, in any state. Same-word load and RESP entry at same edge: response returns OLD value (read-before-write). Load at an earlier edge is visible.
- rst mid-WAIT or mid-RESP: outstanding fetch dropped, no response issued.
- rsp_err and rsp_data are 0 when rsp_valid=0 after reset; otherwise hold last value.

Optional Feature:
IMEM_RANGE_CHECK_EN
- Defined: latched address >= DEPTH*4 -> rsp_err=1, rsp_data=0 (same latency); ld_en with out-of-range ld_addr performs no write.
- Undefined: high address bits ignored; address wraps modulo DEPTH*4; out-of-range load writes the wrapped word.

Test Plan:
- Load 0x20080004 at 0x04, 0x2009000D at 0x08 (WAIT=1); request 0x04 at edge N -> rsp_valid from cycle after N+1, rsp_data=0x20080004, rsp_err=0.
- WAIT=0, req_valid held, rsp_ready=1, addrs 0x04,0x08 -> consecutive responses 0x20080004, 0x2009000D on adjacent cycles, req_ready stays 1.
- Request 0x06 -> rsp_err=1, rsp_data=0; request 0x08 next -> rsp_err=0, rsp_data=0x2009000D.
- rsp_ready=0 for 3 cycles during RESP -> rsp_valid/rsp_data stable, req_ready=0; release -> retire, back to IDLE, busy=0.
- DEPTH=16, request 0x40: with IMEM_RANGE_CHECK_EN -> rsp_err=1, data 0; without -> data = word at 0x00.
- WAIT=3, assert rst one cycle in WAIT -> no rsp_valid ever for that fetch, req_ready=1 next cycle, previously loaded words still read back correctly.
